// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: state encoding and the
// bit-counter width helper.
package ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1
   } ser_state_t;

   // A one-bit word still needs a one-bit counter.
   function automatic int cnt_width(input int width);
      if (width <= 1) begin
         return 1;
      end
      return $clog2(width);
   endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the sequence FSM: one WIDTH-bit word in
// over valid/ready, one bit per clock out, gap-free across back-to-back words.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no word held; ser_out parked at IDLE_BIT, ready for a word
// ST_SHIFT | presenting bit cnt of the current word on ser_out
module bit_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   localparam int              CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] FILL_LO = WIDTH'(IDLE_BIT);
   localparam logic [WIDTH-1:0] FILL_HI = FILL_LO << (WIDTH - 1);

   ser_state_t       state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] sreg, sreg_nxt;
   logic [WIDTH-1:0] sreg_shifted;
   logic             rst_q;
   logic             last_bit;
   logic             accept;

   // Holds load_ready low for the cycle after a reset edge without giving
   // load_ready a combinational path from the rst pin.
   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   assign last_bit   = (state == ST_SHIFT) && (cnt == CNT_LAST);
   assign load_ready = !rst_q && ((state == ST_IDLE) || last_bit);
   assign accept     = load_valid && load_ready;

   assign sreg_shifted = MSB_FIRST ? ((sreg << 1) | FILL_LO)
                                   : ((sreg >> 1) | FILL_HI);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         sreg  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sreg  <= sreg_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sreg_nxt  = sreg;
      if (accept) begin
         // Covers both a load from idle and the zero-gap reload on a last bit.
         state_nxt = ST_SHIFT;
         cnt_nxt   = '0;
         sreg_nxt  = data_in;
      end else begin
         case (state)
            ST_SHIFT: begin
               if (last_bit) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt  = cnt + CW'(1);
                  sreg_nxt = sreg_shifted;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state == ST_SHIFT);
   assign ser_valid = busy;
   assign done      = last_bit;
   assign ser_out   = busy ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: three instances (MSB-first W8,
// LSB-first W8, W1 with idle-high) checked cycle by cycle.
module tb_bit_serializer;
   import ser_pkg::*;

   typedef struct {
      int   cyc;
      logic b;
      logic d;
   } item_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   en = 1'b0;

   item_t qa[$];
   item_t qb[$];
   item_t qc[$];

   logic       a_rst, a_lv, a_rdy, a_so, a_sv, a_bz, a_dn, a_rq;
   logic [7:0] a_d;
   logic       b_rst, b_lv, b_rdy, b_so, b_sv, b_bz, b_dn, b_rq;
   logic [7:0] b_d;
   logic       c_rst, c_lv, c_rdy, c_so, c_sv, c_bz, c_dn, c_rq;
   logic [0:0] c_d;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      a_rq <= a_rst;
      b_rq <= b_rst;
      c_rq <= c_rst;
   end

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
      .clk(clk), .rst(a_rst), .data_in(a_d), .load_valid(a_lv),
      .load_ready(a_rdy), .ser_out(a_so), .ser_valid(a_sv), .busy(a_bz),
      .done(a_dn));

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
      .clk(clk), .rst(b_rst), .data_in(b_d), .load_valid(b_lv),
      .load_ready(b_rdy), .ser_out(b_so), .ser_valid(b_sv), .busy(b_bz),
      .done(b_dn));

   bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_c (
      .clk(clk), .rst(c_rst), .data_in(c_d), .load_valid(c_lv),
      .load_ready(c_rdy), .ser_out(c_so), .ser_valid(c_sv), .busy(c_bz),
      .done(c_dn));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input int id, input logic [31:0] w, input int width,
                            input bit msb, input int start);
      item_t it;
      for (int i = 0; i < width; i++) begin
         it.cyc = start + i;
         it.b   = msb ? w[width-1-i] : w[i];
         it.d   = (i == width - 1);
         case (id)
            0:       qa.push_back(it);
            1:       qb.push_back(it);
            default: qc.push_back(it);
         endcase
      end
   endtask

   // Compare one instance against the head of its scoreboard for this cycle.
   task automatic mon(input int id, input string nm, input logic sv, input logic so,
                      input logic bz, input logic dn, input logic rdy, input logic rq,
                      input logic idle_b);
      item_t it;
      bit    have = 1'b0;
      logic  exp_rdy;
      case (id)
         0: if (qa.size() > 0 && qa[0].cyc == cyc) begin it = qa.pop_front(); have = 1'b1; end
         1: if (qb.size() > 0 && qb[0].cyc == cyc) begin it = qb.pop_front(); have = 1'b1; end
         default: if (qc.size() > 0 && qc[0].cyc == cyc) begin it = qc.pop_front(); have = 1'b1; end
      endcase
      if (have) begin
         chk($sformatf("%s.ser_valid@%0d", nm, cyc), {31'd0, sv}, 32'd1);
         chk($sformatf("%s.busy@%0d", nm, cyc), {31'd0, bz}, 32'd1);
         chk($sformatf("%s.ser_out@%0d", nm, cyc), {31'd0, so}, {31'd0, it.b});
         chk($sformatf("%s.done@%0d", nm, cyc), {31'd0, dn}, {31'd0, it.d});
         exp_rdy = !rq && it.d;
      end else begin
         chk($sformatf("%s.ser_valid@%0d", nm, cyc), {31'd0, sv}, 32'd0);
         chk($sformatf("%s.busy@%0d", nm, cyc), {31'd0, bz}, 32'd0);
         chk($sformatf("%s.ser_out@%0d", nm, cyc), {31'd0, so}, {31'd0, idle_b});
         chk($sformatf("%s.done@%0d", nm, cyc), {31'd0, dn}, 32'd0);
         exp_rdy = !rq;
      end
      chk($sformatf("%s.load_ready@%0d", nm, cyc), {31'd0, rdy}, {31'd0, exp_rdy});
   endtask

   always @(negedge clk) begin
      if (en) begin
         mon(0, "a", a_sv, a_so, a_bz, a_dn, a_rdy, a_rq, 1'b0);
         mon(1, "b", b_sv, b_so, b_bz, b_dn, b_rdy, b_rq, 1'b0);
         mon(2, "c", c_sv, c_so, c_bz, c_dn, c_rdy, c_rq, 1'b1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      item_t tmp;
      logic [7:0] w;
      a_rst = 1'b1; a_lv = 1'b0; a_d = '0;
      b_rst = 1'b1; b_lv = 1'b0; b_d = '0;
      c_rst = 1'b1; c_lv = 1'b0; c_d = '0;
      tick();
      en = 1'b1;
      tick();
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      tick();
      tick();

      // single MSB-first word
      a_lv = 1'b1; a_d = 8'hA5;
      push_word(0, 32'hA5, 8, 1'b1, cyc + 1);
      tick();
      a_lv = 1'b0;
      repeat (10) tick();

      // back-to-back: valid held high, second word waits for the last-bit edge
      a_lv = 1'b1; a_d = 8'hA5;
      push_word(0, 32'hA5, 8, 1'b1, cyc + 1);
      tick();
      a_d = 8'h3C;
      repeat (7) tick();
      push_word(0, 32'h3C, 8, 1'b1, cyc + 1);
      tick();
      a_lv = 1'b0;
      repeat (10) tick();

      // reset during the fourth bit of 8'hF0
      a_lv = 1'b1; a_d = 8'hF0;
      push_word(0, 32'hF0, 8, 1'b1, cyc + 1);
      tick();
      a_lv = 1'b0;
      repeat (3) tick();
      a_rst = 1'b1;
      while (qa.size() > 0 && qa[qa.size()-1].cyc > cyc) tmp = qa.pop_back();
      tick();
      a_rst = 1'b0;
      tick();
      a_lv = 1'b1; a_d = 8'h80;
      push_word(0, 32'h80, 8, 1'b1, cyc + 1);
      tick();
      a_lv = 1'b0;
      repeat (10) tick();

      // LSB-first with a load attempted while busy
      b_lv = 1'b1; b_d = 8'h01;
      push_word(1, 32'h01, 8, 1'b0, cyc + 1);
      tick();
      b_lv = 1'b0;
      tick();
      b_lv = 1'b1; b_d = 8'hFF;
      repeat (6) tick();
      push_word(1, 32'hFF, 8, 1'b0, cyc + 1);
      tick();
      b_lv = 1'b0;
      repeat (10) tick();

      // random words, some back-to-back, some with a gap
      for (int j = 0; j < 6; j++) begin
         w = 8'($urandom);
         b_lv = 1'b1; b_d = w;
         push_word(1, {24'd0, w}, 8, 1'b0, cyc + 1);
         tick();
         b_lv = 1'b0;
         repeat (7) tick();
         if ($urandom_range(0, 1) == 1) tick();
      end
      repeat (3) tick();

      // WIDTH=1: one word per clock, idle level high
      c_lv = 1'b1; c_d = 1'b0;
      push_word(2, 32'd0, 1, 1'b1, cyc + 1);
      tick();
      c_d = 1'b1;
      push_word(2, 32'd1, 1, 1'b1, cyc + 1);
      tick();
      c_d = 1'b0;
      push_word(2, 32'd0, 1, 1'b1, cyc + 1);
      tick();
      c_lv = 1'b0;
      repeat (4) tick();

      chk("qa_drained", qa.size(), 32'd0);
      chk("qb_drained", qb.size(), 32'd0);
      chk("qc_drained", qc.size(), 32'd0);
      en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
